// File: rtl/msrv32_imm_decode_stage.sv
// Decode stage feeding msrv32_imm_generator: registers each fetched instruction,
// decodes its immediate type at capture and presents it through a 2-entry skid buffer.
module msrv32_imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            in_valid_in,
  output logic            in_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid_out,
  input  logic            out_ready_in,
  output logic [24:0]     instr_out,
  output logic [2:0]      imm_type_out,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal_out,
  output logic [1:0]      occupancy_out
);

  typedef struct packed {
    logic [24:0]     instr;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d, new_entry;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic   accept, consume;
  logic [2:0] dec_type;
  logic       dec_ill;

  // Every legal opcode ends in 2'b11, so compressed encodings fall to the default.
  always_comb begin
    dec_type = 3'b000;
    dec_ill  = 1'b0;
    unique case (instr_in[6:0])
      7'b0010011: dec_type = 3'b000;
      7'b0000011,
      7'b1100111: dec_type = 3'b001;
      7'b0100011: dec_type = 3'b010;
      7'b1100011: dec_type = 3'b011;
      7'b0110111,
      7'b0010111: dec_type = 3'b100;
      7'b1101111: dec_type = 3'b101;
      7'b1110011: dec_type = instr_in[14] ? 3'b110 : 3'b000;
      7'b0110011,
      7'b0001111: dec_type = 3'b000;
      default:    dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    new_entry.instr    = instr_in[31:7];
    new_entry.imm_type = dec_type;
    new_entry.pc       = pc_in;
    new_entry.illegal  = dec_ill;
  end

  assign in_ready_out = !skid_vld_q && !flush_in;
  assign accept       = in_valid_in && in_ready_out;
  assign consume      = out_vld_q && out_ready_in;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_in) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Skid is only ever filled while OUT is stalled; it refills OUT on consume.
      if (consume) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (out_vld_q) begin
      if (accept && consume) begin
        out_d = new_entry;
      end else if (accept) begin
        skid_d     = new_entry;
        skid_vld_d = 1'b1;
      end else if (consume) begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      out_d     = new_entry;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid_out = out_vld_q;
  assign instr_out     = out_q.instr;
  assign imm_type_out  = out_q.imm_type;
  assign pc_out        = out_q.pc;
  assign illegal_out   = out_q.illegal;
  assign occupancy_out = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

endmodule
